// File: rtl/mem_responder.sv
// Word store with programmable wait states and a one-cycle ready pulse per access.
// Optional per-word even parity with error injection when MEM_PARITY_EN is defined.
module mem_responder #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              ready,
  output logic              busy,
  output logic              err
`ifdef MEM_PARITY_EN
  ,
  input  logic              perr_inj
`endif
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic [DWIDTH-1:0]   dout_q, dout_d;
  logic                err_q, err_d;
  logic [DWIDTH-1:0]   mem_q [DEPTH];

  // Access port: the single point where the array is read or written.
  logic                acc_en;
  logic                acc_wr;
  logic [AWIDTH-1:0]   acc_addr;
  logic [DWIDTH-1:0]   acc_data;
  logic [DWIDTH-1:0]   rd_word;

`ifdef MEM_PARITY_EN
  logic                perr_q, perr_d;
  logic                acc_perr;
  logic                par_q [DEPTH];
`endif

  assign rd_word = mem_q[acc_addr];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = 1'b0;
    acc_en   = 1'b0;
    acc_wr   = wr_q;
    acc_addr = addr_q;
    acc_data = data_q;
`ifdef MEM_PARITY_EN
    perr_d   = perr_q;
    acc_perr = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_rd && mem_wr) begin
          err_d = 1'b1;
        end else if (mem_rd || mem_wr) begin
          wr_d   = mem_wr;
          addr_d = addr;
          data_d = data_in;
`ifdef MEM_PARITY_EN
          perr_d = perr_inj;
`endif
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            // Zero wait states: the request edge is also the DONE entry edge.
            state_d  = DONE;
            acc_en   = 1'b1;
            acc_wr   = mem_wr;
            acc_addr = addr;
            acc_data = data_in;
`ifdef MEM_PARITY_EN
            acc_perr = perr_inj;
`endif
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dout_d = (acc_en && !acc_wr) ? rd_word : dout_q;
`ifdef MEM_PARITY_EN
    if (acc_en && !acc_wr && ((^rd_word) != par_q[acc_addr])) begin
      err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
`ifdef MEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
`ifdef MEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Array is cleared on reset, so it is held in flops rather than block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef MEM_PARITY_EN
        par_q[i] <= 1'b0;
`endif
      end
    end else if (acc_en && acc_wr) begin
      mem_q[acc_addr] <= acc_data;
`ifdef MEM_PARITY_EN
      par_q[acc_addr] <= (^acc_data) ^ acc_perr;
`endif
    end
  end

  assign data_out = dout_q;
  assign ready    = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule
